// File: rtl/rx_ack_tracker.sv
// rx_ack_tracker: per-flow receive ACK engine (ack number, RX queue tail/head, delayed-ACK coalescing)
// Ports: clk/rst (sync, active-high); i_init_* (re)initialises a flow; i_pkt_*/o_pkt_rdy inbound segment;
// i_head_upd_* application head advance; i_flush_*/o_flush_rdy force pending ACK out;
// o_res_*/i_res_rdy per-segment result; o_ack_*/i_ack_rdy ACK request to the TX generator.
module rx_ack_tracker #(
  parameter int NUM_FLOWS        = 8,
  parameter int FLOWID_W         = 3,
  parameter int SEQ_W            = 32,
  parameter int PAYLOAD_LEN_W    = 16,
  parameter int RX_PAYLOAD_IDX_W = 6,
  parameter int RX_PAYLOAD_PTR_W = 16,
  parameter int ACK_COALESCE     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_init_val,
  input  logic [FLOWID_W-1:0]           i_init_flowid,
  input  logic [SEQ_W-1:0]              i_init_ack_num,
  input  logic                          i_pkt_val,
  output logic                          o_pkt_rdy,
  input  logic [FLOWID_W-1:0]           i_pkt_flowid,
  input  logic [SEQ_W-1:0]              i_pkt_seq_num,
  input  logic [PAYLOAD_LEN_W-1:0]      i_pkt_payload_len,
  input  logic                          i_pkt_malloc_ok,
  input  logic [RX_PAYLOAD_PTR_W:0]     i_pkt_malloc_space,
  input  logic                          i_head_upd_val,
  input  logic [FLOWID_W-1:0]           i_head_upd_flowid,
  input  logic [RX_PAYLOAD_IDX_W:0]     i_head_upd_idx,
  input  logic                          i_flush_val,
  output logic                          o_flush_rdy,
  input  logic [FLOWID_W-1:0]           i_flush_flowid,
  output logic                          o_res_val,
  input  logic                          i_res_rdy,
  output logic [FLOWID_W-1:0]           o_res_flowid,
  output logic                          o_res_accept,
  output logic [SEQ_W-1:0]              o_res_ack_num,
  output logic [RX_PAYLOAD_IDX_W:0]     o_res_tail_idx,
  output logic [RX_PAYLOAD_PTR_W:0]     o_res_our_win,
  output logic                          o_ack_val,
  input  logic                          i_ack_rdy,
  output logic [FLOWID_W-1:0]           o_ack_flowid,
  output logic [SEQ_W-1:0]              o_ack_num,
  output logic                          o_ack_dup
);
  localparam int IW = RX_PAYLOAD_IDX_W + 1;
  localparam int WW = RX_PAYLOAD_PTR_W + 1;
  localparam int CW = $clog2(ACK_COALESCE + 1);
  logic [SEQ_W-1:0] r_ack  [NUM_FLOWS];
  logic [IW-1:0]    r_tail [NUM_FLOWS];
  logic [IW-1:0]    r_head [NUM_FLOWS];
  logic [CW-1:0]    r_cnt  [NUM_FLOWS];
  logic             w_fire, w_flush_fire, w_accept, w_has_len, w_coal, w_ack_req;
  logic [SEQ_W-1:0] w_ack, w_ack_nxt;
  logic [IW-1:0]    w_tail, w_tail_nxt, w_used;
  logic [CW-1:0]    w_cnt_inc, w_flush_cnt;
  logic [WW-1:0]    w_len, w_win;
  always_comb begin
    o_pkt_rdy    = !i_init_val & (!o_res_val | i_res_rdy) & (!o_ack_val | i_ack_rdy);
    w_fire       = i_pkt_val & o_pkt_rdy;
    o_flush_rdy  = !i_init_val & !w_fire & (!o_ack_val | i_ack_rdy);
    w_flush_fire = i_flush_val & o_flush_rdy;
    w_flush_cnt  = r_cnt[i_flush_flowid];
    w_ack        = r_ack[i_pkt_flowid];
    w_tail       = r_tail[i_pkt_flowid];
    // used >= 2^IDX_W shows up as the wrap bit of the modular difference
    w_used       = w_tail - r_head[i_pkt_flowid];
    w_has_len    = |i_pkt_payload_len;
    w_accept     = i_pkt_malloc_ok & !w_used[IW-1] & (i_pkt_seq_num == w_ack) & w_has_len;
    w_ack_nxt    = w_ack + SEQ_W'(i_pkt_payload_len);
    w_tail_nxt   = w_tail + IW'(1);
    w_len        = WW'(i_pkt_payload_len);
    w_win        = !w_accept ? i_pkt_malloc_space :
                   (w_len > i_pkt_malloc_space) ? '0 : i_pkt_malloc_space - w_len;
    w_cnt_inc    = r_cnt[i_pkt_flowid] + CW'(1);
    w_coal       = w_cnt_inc == CW'(ACK_COALESCE);
    w_ack_req    = w_has_len & (!w_accept | w_coal);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        r_ack[i]  <= '0;
        r_tail[i] <= '0;
        r_head[i] <= '0;
        r_cnt[i]  <= '0;
      end
      o_res_val      <= 1'b0;
      o_res_flowid   <= '0;
      o_res_accept   <= 1'b0;
      o_res_ack_num  <= '0;
      o_res_tail_idx <= '0;
      o_res_our_win  <= '0;
      o_ack_val      <= 1'b0;
      o_ack_flowid   <= '0;
      o_ack_num      <= '0;
      o_ack_dup      <= 1'b0;
    end else begin
      if (i_head_upd_val) r_head[i_head_upd_flowid] <= i_head_upd_idx;
      if (w_fire) begin
        if (w_accept) begin
          r_ack[i_pkt_flowid]  <= w_ack_nxt;
          r_tail[i_pkt_flowid] <= w_tail_nxt;
        end
        if (w_has_len) r_cnt[i_pkt_flowid] <= (w_accept & !w_coal) ? w_cnt_inc : '0;
        o_res_val      <= 1'b1;
        o_res_flowid   <= i_pkt_flowid;
        o_res_accept   <= w_accept;
        o_res_ack_num  <= w_accept ? w_ack_nxt : w_ack;
        o_res_tail_idx <= w_accept ? w_tail_nxt : w_tail;
        o_res_our_win  <= w_win;
        // the ACK slot is guaranteed free whenever a segment is taken
        o_ack_val      <= w_ack_req;
        if (w_ack_req) begin
          o_ack_flowid <= i_pkt_flowid;
          o_ack_num    <= w_accept ? w_ack_nxt : w_ack;
          o_ack_dup    <= !w_accept;
        end
      end else begin
        if (i_res_rdy) o_res_val <= 1'b0;
        if (w_flush_fire) begin
          r_cnt[i_flush_flowid] <= '0;
          o_ack_val             <= |w_flush_cnt;
          if (|w_flush_cnt) begin
            o_ack_flowid <= i_flush_flowid;
            o_ack_num    <= r_ack[i_flush_flowid];
            o_ack_dup    <= 1'b0;
          end
        end else if (i_ack_rdy) o_ack_val <= 1'b0;
      end
      if (i_init_val) begin
        r_ack[i_init_flowid]  <= i_init_ack_num;
        r_tail[i_init_flowid] <= '0;
        r_head[i_init_flowid] <= '0;
        r_cnt[i_init_flowid]  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rx_ack_tracker.sv
// tb_rx_ack_tracker: directed and randomized checks of rx_ack_tracker against a flow-level reference model
module tb_rx_ack_tracker;
  localparam int COAL = 2;
  logic clk = 0, rst = 1;
  logic i_init_val = 0;
  logic [2:0] i_init_flowid = 0;
  logic [31:0] i_init_ack_num = 0;
  logic i_pkt_val = 0, o_pkt_rdy;
  logic [2:0] i_pkt_flowid = 0;
  logic [31:0] i_pkt_seq_num = 0;
  logic [15:0] i_pkt_payload_len = 0;
  logic i_pkt_malloc_ok = 0;
  logic [16:0] i_pkt_malloc_space = 0;
  logic i_head_upd_val = 0;
  logic [2:0] i_head_upd_flowid = 0;
  logic [6:0] i_head_upd_idx = 0;
  logic i_flush_val = 0, o_flush_rdy;
  logic [2:0] i_flush_flowid = 0;
  logic o_res_val, i_res_rdy = 1;
  logic [2:0] o_res_flowid;
  logic o_res_accept;
  logic [31:0] o_res_ack_num;
  logic [6:0] o_res_tail_idx;
  logic [16:0] o_res_our_win;
  logic o_ack_val, i_ack_rdy = 1;
  logic [2:0] o_ack_flowid;
  logic [31:0] o_ack_num;
  logic o_ack_dup;
  int tests = 0, fails = 0;
  logic [31:0] m_ack [8];
  int m_tail [8], m_head [8], m_cnt [8];
  logic [2:0] e_f;
  logic e_acc, e_av, e_dup;
  logic [31:0] e_an;
  logic [6:0] e_tl;
  logic [16:0] e_win;

  rx_ack_tracker dut (
    .clk(clk), .rst(rst),
    .i_init_val(i_init_val), .i_init_flowid(i_init_flowid), .i_init_ack_num(i_init_ack_num),
    .i_pkt_val(i_pkt_val), .o_pkt_rdy(o_pkt_rdy), .i_pkt_flowid(i_pkt_flowid),
    .i_pkt_seq_num(i_pkt_seq_num), .i_pkt_payload_len(i_pkt_payload_len),
    .i_pkt_malloc_ok(i_pkt_malloc_ok), .i_pkt_malloc_space(i_pkt_malloc_space),
    .i_head_upd_val(i_head_upd_val), .i_head_upd_flowid(i_head_upd_flowid), .i_head_upd_idx(i_head_upd_idx),
    .i_flush_val(i_flush_val), .o_flush_rdy(o_flush_rdy), .i_flush_flowid(i_flush_flowid),
    .o_res_val(o_res_val), .i_res_rdy(i_res_rdy), .o_res_flowid(o_res_flowid),
    .o_res_accept(o_res_accept), .o_res_ack_num(o_res_ack_num), .o_res_tail_idx(o_res_tail_idx),
    .o_res_our_win(o_res_our_win),
    .o_ack_val(o_ack_val), .i_ack_rdy(i_ack_rdy), .o_ack_flowid(o_ack_flowid),
    .o_ack_num(o_ack_num), .o_ack_dup(o_ack_dup)
  );

  always #5 clk = ~clk;

  task automatic m_seg(input int f, input logic [31:0] seq, input logic [15:0] len, input logic ok, input logic [16:0] sp);
    int used;
    used = (m_tail[f] - m_head[f] + 128) % 128;
    e_f = f[2:0];
    e_acc = ok && used < 64 && seq == m_ack[f] && len != 0;
    e_av = 0; e_dup = 0; e_win = sp;
    if (e_acc) begin
      m_ack[f] = m_ack[f] + 32'(len);
      m_tail[f] = (m_tail[f] + 1) % 128;
      e_win = (int'(len) > int'(sp)) ? 17'd0 : 17'(int'(sp) - int'(len));
      m_cnt[f]++;
      if (m_cnt[f] == COAL) begin e_av = 1; m_cnt[f] = 0; end
    end else if (len != 0) begin
      e_av = 1; e_dup = 1; m_cnt[f] = 0;
    end
    e_an = m_ack[f];
    e_tl = 7'(m_tail[f]);
  endtask

  task automatic set_pkt(input int f, input logic [31:0] seq, input logic [15:0] len, input logic ok, input logic [16:0] sp);
    i_pkt_val = 1; i_pkt_flowid = f[2:0]; i_pkt_seq_num = seq;
    i_pkt_payload_len = len; i_pkt_malloc_ok = ok; i_pkt_malloc_space = sp;
  endtask

  task automatic drive_pkt(input int f, input logic [31:0] seq, input logic [15:0] len, input logic ok, input logic [16:0] sp);
    int n = 0;
    @(negedge clk);
    set_pkt(f, seq, len, ok, sp);
    while (!o_pkt_rdy && n < 100) begin @(negedge clk); n++; end
    if (!o_pkt_rdy) begin tests++; fails++; $display("FAIL pkt_rdy_timeout got=%b exp=1", o_pkt_rdy); end
    @(posedge clk); #1 i_pkt_val = 0;
    m_seg(f, seq, len, ok, sp);
  endtask

  task automatic drive_init(input int f, input logic [31:0] a);
    @(negedge clk);
    i_init_val = 1; i_init_flowid = f[2:0]; i_init_ack_num = a;
    @(posedge clk); #1 i_init_val = 0;
    m_ack[f] = a; m_tail[f] = 0; m_head[f] = 0; m_cnt[f] = 0;
  endtask

  task automatic drive_head(input int f, input int idx);
    @(negedge clk);
    i_head_upd_val = 1; i_head_upd_flowid = f[2:0]; i_head_upd_idx = 7'(idx);
    @(posedge clk); #1 i_head_upd_val = 0;
    m_head[f] = idx;
  endtask

  task automatic drive_flush(input int f);
    int n = 0;
    @(negedge clk);
    i_flush_val = 1; i_flush_flowid = f[2:0];
    while (!o_flush_rdy && n < 100) begin @(negedge clk); n++; end
    if (!o_flush_rdy) begin tests++; fails++; $display("FAIL flush_rdy_timeout got=%b exp=1", o_flush_rdy); end
    @(posedge clk); #1 i_flush_val = 0;
    e_f = f[2:0]; e_av = m_cnt[f] > 0; e_dup = 0; e_an = m_ack[f]; m_cnt[f] = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin m_ack[i] = 0; m_tail[i] = 0; m_head[i] = 0; m_cnt[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o_res_val, o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, o_ack_val, o_ack_num, o_ack_dup} !== '0) begin
      fails++; $display("FAIL reset_outputs got res_val=%b ack_val=%b res_ack=%h ack_num=%h exp all zero", o_res_val, o_ack_val, o_res_ack_num, o_ack_num);
    end
    @(negedge clk) rst = 0;
    tests++;
    if ({o_pkt_rdy, o_flush_rdy} !== 2'b11) begin fails++; $display("FAIL reset_rdy got=%b%b exp=11", o_pkt_rdy, o_flush_rdy); end
    drive_pkt(0, 0, 10, 1, 50);
    tests++;
    if ({o_res_val, o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, o_ack_val} !== {1'b1, 1'b1, 32'd10, 7'd1, 17'd40, 1'b0})
      begin fails++; $display("FAIL reset_flow_state got acc=%b ack=%0d tail=%0d win=%0d ackv=%b exp acc=1 ack=10 tail=1 win=40 ackv=0", o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, o_ack_val); end
  endtask

  task automatic test_coalesce();
    drive_init(2, 1000);
    drive_pkt(2, 1000, 100, 1, 5000);
    tests++;
    if ({o_res_val, o_res_flowid, o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, o_ack_val} !== {1'b1, 3'd2, 1'b1, 32'd1100, 7'd1, 17'd4900, 1'b0})
      begin fails++; $display("FAIL coal_seg1 got acc=%b ack=%0d tail=%0d win=%0d ackv=%b exp acc=1 ack=1100 tail=1 win=4900 ackv=0", o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, o_ack_val); end
    drive_pkt(2, 1100, 50, 1, 5000);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_res_tail_idx, o_ack_val, o_ack_flowid, o_ack_num, o_ack_dup} !== {1'b1, 32'd1150, 7'd2, 1'b1, 3'd2, 32'd1150, 1'b0})
      begin fails++; $display("FAIL coal_seg2 got acc=%b ack=%0d tail=%0d ackv=%b ackf=%0d ackn=%0d dup=%b exp 1 1150 2 1 2 1150 0", o_res_accept, o_res_ack_num, o_res_tail_idx, o_ack_val, o_ack_flowid, o_ack_num, o_ack_dup); end
  endtask

  task automatic test_dup_ack();
    drive_pkt(2, 1200, 10, 1, 3000);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, o_ack_val, o_ack_num, o_ack_dup} !== {1'b0, 32'd1150, 7'd2, 17'd3000, 1'b1, 32'd1150, 1'b1})
      begin fails++; $display("FAIL dup_ooo got acc=%b ack=%0d tail=%0d win=%0d ackv=%b ackn=%0d dup=%b exp 0 1150 2 3000 1 1150 1", o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, o_ack_val, o_ack_num, o_ack_dup); end
    drive_pkt(2, 1150, 10, 1, 3000);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_ack_val} !== {1'b1, 32'd1160, 1'b0})
      begin fails++; $display("FAIL dup_cnt_cleared got acc=%b ack=%0d ackv=%b exp 1 1160 0", o_res_accept, o_res_ack_num, o_ack_val); end
    drive_pkt(2, 1160, 10, 0, 3000);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_ack_val, o_ack_dup} !== {1'b0, 32'd1160, 1'b1, 1'b1})
      begin fails++; $display("FAIL dup_malloc_fail got acc=%b ack=%0d ackv=%b dup=%b exp 0 1160 1 1", o_res_accept, o_res_ack_num, o_ack_val, o_ack_dup); end
  endtask

  task automatic test_queue_full();
    drive_init(3, 0);
    for (int i = 0; i < 64; i++) drive_pkt(3, 32'(i), 1, 1, 1000);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_res_tail_idx} !== {1'b1, 32'd64, 7'd64})
      begin fails++; $display("FAIL qfull_fill got acc=%b ack=%0d tail=%0d exp 1 64 64", o_res_accept, o_res_ack_num, o_res_tail_idx); end
    drive_pkt(3, 64, 1, 1, 1000);
    tests++;
    if ({o_res_accept, o_res_tail_idx, o_ack_val, o_ack_dup, o_ack_num} !== {1'b0, 7'd64, 1'b1, 1'b1, 32'd64})
      begin fails++; $display("FAIL qfull_reject got acc=%b tail=%0d ackv=%b dup=%b ackn=%0d exp 0 64 1 1 64", o_res_accept, o_res_tail_idx, o_ack_val, o_ack_dup, o_ack_num); end
    @(negedge clk);
    set_pkt(3, 64, 1, 1, 1000);
    i_head_upd_val = 1; i_head_upd_flowid = 3; i_head_upd_idx = 1;
    @(posedge clk); #1 i_pkt_val = 0; i_head_upd_val = 0;
    m_seg(3, 64, 1, 1, 1000);
    m_head[3] = 1;
    tests++;
    if ({o_res_val, o_res_accept, o_res_tail_idx} !== {1'b1, 1'b0, 7'd64})
      begin fails++; $display("FAIL qfull_old_head got v=%b acc=%b tail=%0d exp 1 0 64", o_res_val, o_res_accept, o_res_tail_idx); end
    drive_pkt(3, 64, 1, 1, 1000);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_res_tail_idx} !== {1'b1, 32'd65, 7'd65})
      begin fails++; $display("FAIL qfull_retry got acc=%b ack=%0d tail=%0d exp 1 65 65", o_res_accept, o_res_ack_num, o_res_tail_idx); end
  endtask

  task automatic test_wrap_window();
    drive_init(4, 32'hFFFF_FFF0);
    drive_pkt(4, 32'hFFFF_FFF0, 16'h20, 1, 100);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_res_our_win} !== {1'b1, 32'h10, 17'd68})
      begin fails++; $display("FAIL wrap_ack got acc=%b ack=%h win=%0d exp 1 00000010 68", o_res_accept, o_res_ack_num, o_res_our_win); end
    drive_pkt(4, 32'h10, 20, 1, 10);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_res_our_win, o_ack_val, o_ack_num} !== {1'b1, 32'h24, 17'd0, 1'b1, 32'h24})
      begin fails++; $display("FAIL win_saturate got acc=%b ack=%h win=%0d ackv=%b ackn=%h exp 1 24 0 1 24", o_res_accept, o_res_ack_num, o_res_our_win, o_ack_val, o_ack_num); end
    drive_pkt(4, 32'h24, 10, 1, 10);
    tests++;
    if ({o_res_accept, o_res_our_win} !== {1'b1, 17'd0})
      begin fails++; $display("FAIL win_exact got acc=%b win=%0d exp 1 0", o_res_accept, o_res_our_win); end
    drive_pkt(4, 32'h2E, 0, 1, 77);
    tests++;
    if ({o_res_val, o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, o_ack_val} !== {1'b1, 1'b0, 32'h2E, 7'd3, 17'd77, 1'b0})
      begin fails++; $display("FAIL pure_ack got acc=%b ack=%h tail=%0d win=%0d ackv=%b exp 0 2e 3 77 0", o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, o_ack_val); end
  endtask

  task automatic test_backpressure();
    drive_init(5, 0);
    i_res_rdy = 0; i_ack_rdy = 0;
    drive_pkt(5, 7, 10, 1, 100);
    @(negedge clk);
    set_pkt(5, 0, 10, 1, 100);
    tests++;
    if ({o_pkt_rdy, o_flush_rdy} !== 2'b00) begin fails++; $display("FAIL bp_rdy got=%b%b exp=00", o_pkt_rdy, o_flush_rdy); end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o_res_val, o_res_flowid, o_res_accept, o_res_ack_num, o_ack_val, o_ack_flowid, o_ack_num, o_ack_dup} !== {1'b1, 3'd5, 1'b0, 32'd0, 1'b1, 3'd5, 32'd0, 1'b1})
      begin fails++; $display("FAIL bp_hold got rv=%b acc=%b av=%b dup=%b ackn=%0d exp 1 0 1 1 0", o_res_val, o_res_accept, o_ack_val, o_ack_dup, o_ack_num); end
    @(negedge clk) i_ack_rdy = 1;
    #1;
    tests++;
    if (o_pkt_rdy !== 1'b0) begin fails++; $display("FAIL bp_res_blocks got=%b exp=0", o_pkt_rdy); end
    i_res_rdy = 1;
    @(posedge clk); #1 i_pkt_val = 0;
    m_seg(5, 0, 10, 1, 100);
    tests++;
    if ({o_res_val, o_res_accept, o_res_ack_num, o_res_tail_idx, o_ack_val} !== {1'b1, 1'b1, 32'd10, 7'd1, 1'b0})
      begin fails++; $display("FAIL bp_release got rv=%b acc=%b ack=%0d tail=%0d av=%b exp 1 1 10 1 0", o_res_val, o_res_accept, o_res_ack_num, o_res_tail_idx, o_ack_val); end
  endtask

  task automatic test_flush_init();
    drive_init(6, 0);
    drive_pkt(6, 0, 10, 1, 100);
    drive_flush(6);
    tests++;
    if ({o_ack_val, o_ack_flowid, o_ack_num, o_ack_dup} !== {1'b1, 3'd6, 32'd10, 1'b0})
      begin fails++; $display("FAIL flush_ack got av=%b f=%0d n=%0d dup=%b exp 1 6 10 0", o_ack_val, o_ack_flowid, o_ack_num, o_ack_dup); end
    drive_flush(6);
    tests++;
    if (o_ack_val !== 1'b0) begin fails++; $display("FAIL flush_noop got=%b exp=0", o_ack_val); end
    drive_pkt(6, 10, 10, 1, 100);
    tests++;
    if ({o_res_accept, o_ack_val} !== 2'b10) begin fails++; $display("FAIL flush_cnt_cleared got=%b%b exp=10", o_res_accept, o_ack_val); end
    @(negedge clk);
    set_pkt(6, 20, 5, 1, 100);
    i_init_val = 1; i_init_flowid = 6; i_init_ack_num = 500;
    #1;
    tests++;
    if ({o_pkt_rdy, o_flush_rdy} !== 2'b00) begin fails++; $display("FAIL init_blocks got=%b%b exp=00", o_pkt_rdy, o_flush_rdy); end
    @(posedge clk); #1 i_pkt_val = 0; i_init_val = 0;
    m_ack[6] = 500; m_tail[6] = 0; m_head[6] = 0; m_cnt[6] = 0;
    tests++;
    if (o_res_val !== 1'b0) begin fails++; $display("FAIL init_no_res got=%b exp=0", o_res_val); end
    drive_pkt(6, 500, 5, 1, 100);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_res_tail_idx, o_ack_val} !== {1'b1, 32'd505, 7'd1, 1'b0})
      begin fails++; $display("FAIL init_reset_flow got acc=%b ack=%0d tail=%0d av=%b exp 1 505 1 0", o_res_accept, o_res_ack_num, o_res_tail_idx, o_ack_val); end
  endtask

  task automatic test_back_to_back();
    drive_init(1, 100);
    @(negedge clk);
    set_pkt(1, 100, 10, 1, 1000);
    @(posedge clk); #1;
    m_seg(1, 100, 10, 1, 1000);
    set_pkt(1, 110, 10, 1, 1000);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_res_tail_idx} !== {1'b1, 32'd110, 7'd1})
      begin fails++; $display("FAIL b2b_first got acc=%b ack=%0d tail=%0d exp 1 110 1", o_res_accept, o_res_ack_num, o_res_tail_idx); end
    @(posedge clk); #1 i_pkt_val = 0;
    m_seg(1, 110, 10, 1, 1000);
    tests++;
    if ({o_res_accept, o_res_ack_num, o_res_tail_idx, o_ack_val, o_ack_num} !== {1'b1, 32'd120, 7'd2, 1'b1, 32'd120})
      begin fails++; $display("FAIL b2b_second got acc=%b ack=%0d tail=%0d av=%b ackn=%0d exp 1 120 2 1 120", o_res_accept, o_res_ack_num, o_res_tail_idx, o_ack_val, o_ack_num); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 600; it++) begin
      int f, op, used;
      f = int'($urandom_range(0, 7));
      op = int'($urandom_range(0, 19));
      if (op == 0) drive_init(f, $urandom);
      else if (op < 3) begin
        used = (m_tail[f] - m_head[f] + 128) % 128;
        drive_head(f, (m_tail[f] - int'($urandom_range(0, used)) + 128) % 128);
      end else if (op < 5) begin
        drive_flush(f);
        tests++;
        if (e_av ? ({o_ack_val, o_ack_flowid, o_ack_num, o_ack_dup} !== {1'b1, e_f, e_an, 1'b0}) : (o_ack_val !== 1'b0))
          begin fails++; $display("FAIL rnd_flush it=%0d got av=%b f=%0d n=%h exp av=%b f=%0d n=%h", it, o_ack_val, o_ack_flowid, o_ack_num, e_av, e_f, e_an); end
      end else begin
        logic [31:0] seq;
        logic [15:0] len;
        seq = ($urandom_range(0, 3) != 0) ? m_ack[f] : m_ack[f] + $urandom_range(1, 1000);
        len = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 3000));
        drive_pkt(f, seq, len, $urandom_range(0, 7) != 0, 17'($urandom_range(0, 65536)));
        tests++;
        if ({o_res_val, o_res_flowid, o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win} !== {1'b1, e_f, e_acc, e_an, e_tl, e_win})
          begin fails++; $display("FAIL rnd_res it=%0d got f=%0d acc=%b ack=%h tail=%0d win=%0d exp f=%0d acc=%b ack=%h tail=%0d win=%0d", it, o_res_flowid, o_res_accept, o_res_ack_num, o_res_tail_idx, o_res_our_win, e_f, e_acc, e_an, e_tl, e_win); end
        tests++;
        if (e_av ? ({o_ack_val, o_ack_flowid, o_ack_num, o_ack_dup} !== {1'b1, e_f, e_an, e_dup}) : (o_ack_val !== 1'b0))
          begin fails++; $display("FAIL rnd_ack it=%0d got av=%b f=%0d n=%h dup=%b exp av=%b f=%0d n=%h dup=%b", it, o_ack_val, o_ack_flowid, o_ack_num, o_ack_dup, e_av, e_f, e_an, e_dup); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_coalesce();
    test_dup_ack();
    test_queue_full();
    test_wrap_window();
    test_backpressure();
    test_flush_init();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
